audio_path_sched: RTL and testbench

//  Sequences each received 16-bit audio sample through the audio path.

---
 rtl/audio_path_sched.sv | 185 ++++++++++++++++++
 tb/tb_audio_path_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_path_sched.sv
// Audio sample scheduler: bypass/effect routing, effect timeout fallback, 1-deep input buffer, mode debounce.
// Optional drop counter port drop_cnt enabled by defining SCHED_DROP_COUNT_EN.
module audio_path_sched #(
  parameter int clock_max   = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int EFF_TIMEOUT = 1024
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        in_valid,
  input  logic [15:0] in_audio,
  output logic        eff_start,
  output logic [15:0] eff_sample,
  input  logic        eff_done,
  input  logic [15:0] eff_audio,
  input  logic        dac_ready,
  output logic        dac_valid,
  output logic [15:0] dac_audio,
  output logic        mode_effect,
  output logic        eff_fault
`ifdef SCHED_DROP_COUNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int DB_CYCLES = (clock_max / 1000) * DEBOUNCE_MS;
  localparam int DB_W      = $clog2(DB_CYCLES + 1);
  localparam int TMO_W     = $clog2(EFF_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_ISSUE} state_t;

  state_t             state_q, state_d;
  logic               pend_full_q, pend_full_d;
  logic [15:0]        pend_q, pend_d;
  logic [15:0]        result_q, result_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               eff_start_q, eff_start_d;
  logic [15:0]        eff_sample_q, eff_sample_d;
  logic               dac_valid_q, dac_valid_d;
  logic [15:0]        dac_audio_q, dac_audio_d;
  logic               fault_q, fault_d;
  logic               mode_q, mode_d;
  logic               btn_q, btn_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [15:0]        take_sample;
  logic               drop_ev;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_full_q  <= 1'b0;
      pend_q       <= '0;
      result_q     <= '0;
      tmo_q        <= '0;
      eff_start_q  <= 1'b0;
      eff_sample_q <= '0;
      dac_valid_q  <= 1'b0;
      dac_audio_q  <= '0;
      fault_q      <= 1'b0;
      mode_q       <= 1'b0;
      btn_q        <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_full_q  <= pend_full_d;
      pend_q       <= pend_d;
      result_q     <= result_d;
      tmo_q        <= tmo_d;
      eff_start_q  <= eff_start_d;
      eff_sample_q <= eff_sample_d;
      dac_valid_q  <= dac_valid_d;
      dac_audio_q  <= dac_audio_d;
      fault_q      <= fault_d;
      mode_q       <= mode_d;
      btn_q        <= btn_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_full_d  = pend_full_q;
    pend_d       = pend_q;
    result_d     = result_q;
    tmo_d        = tmo_q;
    eff_start_d  = 1'b0;
    eff_sample_d = eff_sample_q;
    dac_valid_d  = 1'b0;
    dac_audio_d  = dac_audio_q;
    fault_d      = fault_q;
    mode_d       = mode_q;
    btn_d        = btn_q;
    db_cnt_d     = '0;
    take_sample  = pend_full_q ? pend_q : in_audio;
    drop_ev      = 1'b0;

    // Only a change held for the full window is accepted; rising edges toggle the mode.
    if (mode_btn != btn_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        btn_d = mode_btn;
        if (mode_btn) mode_d = ~mode_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_full_q || in_valid) begin
          if (pend_full_q) begin
            pend_full_d = in_valid;
            if (in_valid) pend_d = in_audio;
          end
          if (mode_q) begin
            state_d      = S_PROC;
            eff_start_d  = 1'b1;
            eff_sample_d = take_sample;
            tmo_d        = '0;
          end else begin
            state_d  = S_ISSUE;
            result_d = take_sample;
          end
        end
      end
      S_PROC: begin
        tmo_d = tmo_q + 1'b1;
        if (eff_done) begin
          result_d = eff_audio;
          state_d  = S_ISSUE;
        end else if (tmo_q == TMO_W'(EFF_TIMEOUT - 1)) begin
          // eff_sample_q still holds the original sample for the fallback.
          result_d = eff_sample_q;
          fault_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dac_ready) begin
          dac_valid_d = 1'b1;
          dac_audio_d = result_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && in_valid) begin
      if (!pend_full_q) begin
        pend_full_d = 1'b1;
        pend_d      = in_audio;
      end else begin
        drop_ev = 1'b1;
      end
    end
  end

  assign eff_start   = eff_start_q;
  assign eff_sample  = eff_sample_q;
  assign dac_valid   = dac_valid_q;
  assign dac_audio   = dac_audio_q;
  assign mode_effect = mode_q;
  assign eff_fault   = fault_q;

`ifdef SCHED_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_ev && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_ev;
`endif

endmodule

// File: tb/tb_audio_path_sched.sv
// Directed bench for audio_path_sched: bypass, effect, timeout, buffering, debounce and reset scenarios.
// Short debounce (8 cycles) and timeout (16 cycles) parameters keep the run brief.
module tb_audio_path_sched;

  localparam int TMO = 16;
  localparam int DB  = 8;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        mode_btn;
  logic        in_valid;
  logic [15:0] in_audio;
  logic        eff_start;
  logic [15:0] eff_sample;
  logic        eff_done;
  logic [15:0] eff_audio;
  logic        dac_ready;
  logic        dac_valid;
  logic [15:0] dac_audio;
  logic        mode_effect;
  logic        eff_fault;
`ifdef SCHED_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  audio_path_sched #(
    .clock_max  (4000),
    .DEBOUNCE_MS(2),
    .EFF_TIMEOUT(TMO)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .in_valid   (in_valid),
    .in_audio   (in_audio),
    .eff_start  (eff_start),
    .eff_sample (eff_sample),
    .eff_done   (eff_done),
    .eff_audio  (eff_audio),
    .dac_ready  (dac_ready),
    .dac_valid  (dac_valid),
    .dac_audio  (dac_audio),
    .mode_effect(mode_effect),
    .eff_fault  (eff_fault)
`ifdef SCHED_DROP_COUNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk_25mhz = ~clk_25mhz;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    tick(DB + 4);
    mode_btn = 1'b0;
    tick(DB + 4);
  endtask

  task automatic test_reset();
    reset = 1'b1; mode_btn = 1'b0; in_valid = 1'b0; in_audio = '0;
    eff_done = 1'b0; eff_audio = '0; dac_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    checks++;
    if ({dac_valid, eff_start, mode_effect, eff_fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {dac_valid, eff_start, mode_effect, eff_fault});
    end
    checks++;
    if ({dac_audio, eff_sample} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00000000", {dac_audio, eff_sample});
    end
    $display("reset: outputs dac_valid=%b mode=%b fault=%b", dac_valid, mode_effect, eff_fault);
  endtask

  task automatic test_bypass();
    logic saw_start;
    saw_start = 1'b0;
    in_valid = 1'b1; in_audio = 16'h1234;
    tick();                        // edge k
    in_valid = 1'b0;
    saw_start |= eff_start;
    checks++;
    if (dac_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_early: dac_valid got %b expected 0", dac_valid);
    end
    tick();                        // edge k+1 -> seen at k+2
    saw_start |= eff_start;
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'h1234) begin
      errors++; $display("FAIL bypass_out: got valid=%b audio=%h expected 1/1234", dac_valid, dac_audio);
    end
    tick();
    saw_start |= eff_start;
    checks++;
    if (dac_valid !== 1'b0 || saw_start !== 1'b0) begin
      errors++; $display("FAIL bypass_pulse: got valid=%b eff_start_seen=%b expected 0/0", dac_valid, saw_start);
    end
    $display("bypass: sample 1234 -> dac %h", dac_audio);
  endtask

  task automatic test_effect();
    press_mode();
    checks++;
    if (mode_effect !== 1'b1) begin
      errors++; $display("FAIL effect_mode: got %b expected 1", mode_effect);
    end
    in_valid = 1'b1; in_audio = 16'h8000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (eff_start !== 1'b1 || eff_sample !== 16'h8000) begin
      errors++; $display("FAIL effect_start: got start=%b sample=%h expected 1/8000", eff_start, eff_sample);
    end
    tick(4);
    eff_done = 1'b1; eff_audio = 16'h0F0F;
    tick();
    eff_done = 1'b0;
    checks++;
    if (dac_valid !== 1'b0 || eff_start !== 1'b0) begin
      errors++; $display("FAIL effect_early: got valid=%b start=%b expected 0/0", dac_valid, eff_start);
    end
    tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'h0F0F || eff_fault !== 1'b0) begin
      errors++; $display("FAIL effect_out: got valid=%b audio=%h fault=%b expected 1/0f0f/0", dac_valid, dac_audio, eff_fault);
    end
    $display("effect: sample 8000 -> dac %h", dac_audio);
    tick();
  endtask

  // eff_done on the very cycle the timeout would fire must win.
  task automatic test_done_timeout_tie();
    in_valid = 1'b1; in_audio = 16'h7777;
    tick();
    in_valid = 1'b0;
    tick(TMO - 1);
    eff_done = 1'b1; eff_audio = 16'hBEEF;
    tick();
    eff_done = 1'b0;
    tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'hBEEF || eff_fault !== 1'b0) begin
      errors++; $display("FAIL tie: got valid=%b audio=%h fault=%b expected 1/beef/0", dac_valid, dac_audio, eff_fault);
    end
    $display("tie: dac %h fault %b", dac_audio, eff_fault);
    tick();
  endtask

  task automatic test_bounce();
    // effect mode is active here; glitches must not toggle it
    mode_btn = 1'b1; tick(4);
    mode_btn = 1'b0; tick(4);
    mode_btn = 1'b1; tick(DB - 1);
    mode_btn = 1'b0; tick(DB + 4);
    checks++;
    if (mode_effect !== 1'b1) begin
      errors++; $display("FAIL bounce_mode: got %b expected 1", mode_effect);
    end
    in_valid = 1'b1; in_audio = 16'h1111;
    tick();
    in_valid = 1'b0;
    mode_btn = 1'b1;
    tick(DB + 1);
    mode_btn = 1'b0;
    checks++;
    if (mode_effect !== 1'b0) begin
      errors++; $display("FAIL bounce_toggle: got %b expected 0", mode_effect);
    end
    eff_done = 1'b1; eff_audio = 16'h2222;
    tick();
    eff_done = 1'b0;
    tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'h2222) begin
      errors++; $display("FAIL bounce_inflight: got valid=%b audio=%h expected 1/2222", dac_valid, dac_audio);
    end
    $display("bounce: mode=%b inflight dac %h", mode_effect, dac_audio);
    tick(DB + 4);
  endtask

  task automatic test_back_to_back();
    dac_ready = 1'b0;
    in_valid = 1'b1; in_audio = 16'hAAAA; tick();
    in_audio = 16'hBBBB; tick();
    in_audio = 16'hCCCC; tick();
    in_valid = 1'b0;
    tick(3);
    checks++;
    if (dac_valid !== 1'b0) begin
      errors++; $display("FAIL bp_hold: dac_valid got %b expected 0", dac_valid);
    end
`ifdef SCHED_DROP_COUNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++; $display("FAIL bp_drop: drop_cnt got %0d expected 1", drop_cnt);
    end
`endif
    dac_ready = 1'b1;
    tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'hAAAA) begin
      errors++; $display("FAIL bp_first: got valid=%b audio=%h expected 1/aaaa", dac_valid, dac_audio);
    end
    tick();
    checks++;
    if (dac_valid !== 1'b0) begin
      errors++; $display("FAIL bp_gap: dac_valid got %b expected 0", dac_valid);
    end
    tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_audio !== 16'hBBBB) begin
      errors++; $display("FAIL bp_second: got valid=%b audio=%h expected 1/bbbb", dac_valid, dac_audio);
    end
    tick(3);
    checks++;
    if (dac_valid !== 1'b0 || dac_audio !== 16'hBBBB) begin
      errors++; $display("FAIL bp_no_c: got valid=%b audio=%h expected 0/bbbb", dac_valid, dac_audio);
    end
    $display("backpressure: sequence aaaa, bbbb; cccc dropped");
  endtask

  task automatic test_timeout();
    int n;
    press_mode();
    // eff_done while idle must be ignored
    eff_done = 1'b1; eff_audio = 16'hDEAD;
    tick();
    eff_done = 1'b0;
    tick(2);
    checks++;
    if (dac_valid !== 1'b0 || mode_effect !== 1'b1) begin
      errors++; $display("FAIL stray_done: got valid=%b mode=%b expected 0/1", dac_valid, mode_effect);
    end
    in_valid = 1'b1; in_audio = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (dac_valid !== 1'b1 && n < 4 * TMO) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TMO + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO + 1);
    end
    checks++;
    if (dac_audio !== 16'h5A5A || eff_fault !== 1'b1) begin
      errors++; $display("FAIL timeout_out: got audio=%h fault=%b expected 5a5a/1", dac_audio, eff_fault);
    end
    tick(5);
    checks++;
    if (eff_fault !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b expected 1", eff_fault);
    end
    $display("timeout: dac %h after %0d cycles, fault %b", dac_audio, n, eff_fault);
  endtask

  task automatic test_reset_midop();
    int seen;
    in_valid = 1'b1; in_audio = 16'h3C3C; tick();
    in_audio = 16'h4D4D; tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({dac_valid, eff_start, mode_effect, eff_fault} !== 4'b0000 || {dac_audio, eff_sample} !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: got flags=%b data=%h expected 0000/00000000",
               {dac_valid, eff_start, mode_effect, eff_fault}, {dac_audio, eff_sample});
    end
    eff_done = 1'b1; eff_audio = 16'h9999;
    tick();
    eff_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (dac_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midop_quiet: dac_valid pulses got %0d expected 0", seen);
    end
    $display("reset mid-op: pulses after reset %0d", seen);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_effect();
    test_done_timeout_tie();
    test_bounce();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
